// File: rtl/psram_port_arbiter.sv
// Shares one PSRAM controller command port between a burst writer and a burst reader,
// sequencing command issue, data beats and the mandatory inter-command gap with round-robin grants.
module psram_port_arbiter #(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 32,
    parameter int BURST_BEATS = 8,
    parameter int CMD_GAP     = 14,
    parameter int RD_TIMEOUT  = 63
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_done,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data_in,
    output logic                wr_grant,
    output logic                wr_data_rd,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_grant,
    output logic [DATA_W-1:0]   rd_word,
    output logic                rd_word_valid,
    output logic                rd_done,
    output logic                cmd,
    output logic                cmd_en,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] data_mask,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                rd_data_valid,
    output logic                busy,
    output logic                error
);

    localparam int BEAT_W = $clog2(BURST_BEATS + 1);
    localparam int GAP_W  = $clog2(CMD_GAP + 1);
    localparam int WAIT_W = $clog2(RD_TIMEOUT + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_BEATS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CMD_GAP - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ARB,
        ST_WR_BURST,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                last_wr_q, last_wr_d;
    logic                error_q, error_d;
    logic [DATA_W-1:0]   rd_word_q, rd_word_d;
    logic                rd_word_valid_q, rd_word_valid_d;
    logic                rd_done_q, rd_done_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                rd_accept;

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        gap_d           = '0;
        wait_d          = '0;
        last_wr_d       = last_wr_q;
        error_d         = error_q;
        rd_word_d       = rd_word_q;
        rd_word_valid_d = 1'b0;
        rd_done_d       = 1'b0;
        wr_grant        = 1'b0;
        rd_grant        = 1'b0;
        cmd_en          = 1'b0;
        cmd             = 1'b0;
        addr            = '0;
        wr_data_rd      = 1'b0;
        rd_accept       = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (init_done) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (init_done && (wr_req || rd_req)) begin
                    // Write wins when alone or when the previous grant went to the reader.
                    if (wr_req && (!rd_req || !last_wr_q)) begin
                        wr_grant   = 1'b1;
                        cmd_en     = 1'b1;
                        cmd        = 1'b1;
                        addr       = wr_addr;
                        wr_data_rd = 1'b1;
                        last_wr_d  = 1'b1;
                        beat_d     = BEAT_W'(1);
                        state_d    = (BURST_BEATS == 1) ? ST_GAP : ST_WR_BURST;
                    end else begin
                        rd_grant  = 1'b1;
                        cmd_en    = 1'b1;
                        addr      = rd_addr;
                        last_wr_d = 1'b0;
                        beat_d    = '0;
                        wait_d    = WAIT_W'(1);
                        state_d   = ST_RD_WAIT;
                    end
                end
            end
            ST_WR_BURST: begin
                wr_data_rd = 1'b1;
                beat_d     = beat_q + 1'b1;
                if (beat_q == BEAT_LAST) state_d = ST_GAP;
            end
            ST_RD_WAIT: begin
                if (rd_data_valid) begin
                    rd_accept = 1'b1;
                    beat_d    = BEAT_W'(1);
                    if (BURST_BEATS == 1) begin
                        rd_done_d = 1'b1;
                        state_d   = ST_GAP;
                    end else begin
                        state_d = ST_RD_DATA;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    error_d   = 1'b1;
                    rd_done_d = 1'b1;
                    state_d   = ST_GAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (rd_data_valid) begin
                    rd_accept = 1'b1;
                    beat_d    = beat_q + 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        rd_done_d = 1'b1;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) state_d = ST_ARB;
            end
            default: state_d = ST_INIT;
        endcase

        // Any valid not consumed by an active read burst is a protocol fault.
        if (rd_data_valid && !rd_accept) error_d = 1'b1;
        rd_word_valid_d = rd_accept;
        if (rd_accept) rd_word_d = rd_data;

        wr_data_d = wr_data_rd ? wr_data_in : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_INIT;
            beat_q          <= '0;
            gap_q           <= '0;
            wait_q          <= '0;
            last_wr_q       <= 1'b0;
            error_q         <= 1'b0;
            rd_word_q       <= '0;
            rd_word_valid_q <= 1'b0;
            rd_done_q       <= 1'b0;
            wr_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            gap_q           <= gap_d;
            wait_q          <= wait_d;
            last_wr_q       <= last_wr_d;
            error_q         <= error_d;
            rd_word_q       <= rd_word_d;
            rd_word_valid_q <= rd_word_valid_d;
            rd_done_q       <= rd_done_d;
            wr_data_q       <= wr_data_d;
        end
    end

    assign wr_data       = wr_data_d;
    assign rd_word       = rd_word_q;
    assign rd_word_valid = rd_word_valid_q;
    assign rd_done       = rd_done_q;
    assign error         = error_q;
    assign data_mask     = '0;
    // INIT is reported idle so every output reads 0 straight out of reset.
    assign busy          = (state_q != ST_ARB) && (state_q != ST_INIT);

endmodule
